// File: rtl/feature_window_scheduler.sv
// feature_window_scheduler
//   Sequences the coefficient-pair window buffer feeding the NN classifier. Upstream pairs
//   are gated into the buffer while filling (or sliding by one hop). The window is then held
//   frozen while the buffer settles and the NN runs. A one-cycle nn_start is issued once the
//   window has settled.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   flush                  restart: discard window, back to FILL
//   in_valid/in_data1/2    upstream pair (cannot stall)
//   in_ready               pair will be accepted this cycle
//   fifo_valid/data1/2     registered write into the window buffer
//   fifo_clr               one-cycle buffer clear
//   nn_start / nn_done     inference handshake
//   window_busy            window frozen (SETTLE/START/BUSY)
//   timeout_err            one-cycle pulse when nn_done never arrives
//   infer_cnt / drop_cnt   inferences started (wraps) / pairs lost (saturates)
module feature_window_scheduler #(
    parameter int unsigned NN_DATA_WIDTH  = 16,
    parameter int unsigned NN_ARRAY_WIDTH = 26,
    parameter int unsigned HOP_PAIRS      = 13,
    parameter int unsigned SETTLE_CYC     = 2,
    parameter int unsigned NN_TIMEOUT     = 4096
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [NN_DATA_WIDTH-1:0] in_data1,
    input  logic [NN_DATA_WIDTH-1:0] in_data2,
    output logic                     in_ready,
    output logic                     fifo_valid,
    output logic [NN_DATA_WIDTH-1:0] fifo_data1,
    output logic [NN_DATA_WIDTH-1:0] fifo_data2,
    output logic                     fifo_clr,
    output logic                     nn_start,
    input  logic                     nn_done,
    output logic                     window_busy,
    output logic                     timeout_err,
    output logic [15:0]              infer_cnt,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned FILL_PAIRS = NN_ARRAY_WIDTH / 2;
    localparam int unsigned PAIR_W     = $clog2(FILL_PAIRS + 1);
    localparam int unsigned SET_W      = $clog2(SETTLE_CYC + 1);
    localparam int unsigned TO_W       = $clog2(NN_TIMEOUT + 1);

    typedef enum logic [2:0] {StFill, StSettle, StStart, StBusy, StSlide} state_e;

    state_e            state_q;
    logic [PAIR_W-1:0] pair_cnt_q;
    logic [SET_W-1:0]  settle_cnt_q;
    logic [TO_W-1:0]   timeout_cnt_q;

    logic accept;
    logic drop;
    logic pair_last;

    // A pair arriving in a flush cycle is discarded silently (neither written nor counted).
    assign accept    = in_valid && in_ready && !flush;
    assign drop      = in_valid && !in_ready && !flush;
    assign pair_last = (state_q == StFill) ? (pair_cnt_q == PAIR_W'(FILL_PAIRS - 1))
                                           : (pair_cnt_q == PAIR_W'(HOP_PAIRS - 1));

    assign window_busy = (state_q == StSettle) || (state_q == StStart) || (state_q == StBusy);

    // in_ready is kept as its own register so it reads 0 in the cycle right after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StFill;
            pair_cnt_q    <= '0;
            settle_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            in_ready      <= 1'b0;
            fifo_valid    <= 1'b0;
            fifo_data1    <= '0;
            fifo_data2    <= '0;
            fifo_clr      <= 1'b1;
            nn_start      <= 1'b0;
            timeout_err   <= 1'b0;
            infer_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            fifo_clr    <= 1'b0;
            nn_start    <= 1'b0;
            timeout_err <= 1'b0;
            fifo_valid  <= accept;
            if (accept) begin
                fifo_data1 <= in_data1;
                fifo_data2 <= in_data2;
            end
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end

            if (flush) begin
                state_q       <= StFill;
                in_ready      <= 1'b1;
                fifo_clr      <= 1'b1;
                pair_cnt_q    <= '0;
                settle_cnt_q  <= '0;
                timeout_cnt_q <= '0;
            end else begin
                case (state_q)
                    StFill, StSlide: begin
                        in_ready <= 1'b1;
                        if (accept) begin
                            if (pair_last) begin
                                // Transition on the edge that takes the final pair.
                                state_q      <= StSettle;
                                in_ready     <= 1'b0;
                                pair_cnt_q   <= '0;
                                settle_cnt_q <= '0;
                            end else begin
                                pair_cnt_q <= pair_cnt_q + 1'b1;
                            end
                        end
                    end
                    StSettle: begin
                        if (settle_cnt_q == SET_W'(SETTLE_CYC - 1)) begin
                            state_q   <= StStart;
                            nn_start  <= 1'b1;
                            infer_cnt <= infer_cnt + 16'd1;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end
                    StStart: begin
                        state_q       <= StBusy;
                        timeout_cnt_q <= '0;
                    end
                    StBusy: begin
                        // nn_done wins over a coincident terminal count.
                        if (nn_done) begin
                            state_q  <= StSlide;
                            in_ready <= 1'b1;
                        end else if (timeout_cnt_q == TO_W'(NN_TIMEOUT - 1)) begin
                            state_q     <= StSlide;
                            in_ready    <= 1'b1;
                            timeout_err <= 1'b1;
                        end else begin
                            timeout_cnt_q <= timeout_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q  <= StFill;
                        in_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_feature_window_scheduler.sv
// Directed bench for feature_window_scheduler.
//   dut_a: HOP_PAIRS=4, NN_TIMEOUT=16 (fill, busy drops, slide, timeout, flush).
//   dut_b: default hop, very long timeout (drop_cnt saturation, late nn_done).
module tb_feature_window_scheduler;

    logic clk;
    logic rst_n;

    logic        flush_a, in_valid_a, nn_done_a;
    logic [15:0] in_data1_a, in_data2_a;
    logic        in_ready_a, fifo_valid_a, fifo_clr_a, nn_start_a, window_busy_a, timeout_err_a;
    logic [15:0] fifo_data1_a, fifo_data2_a, infer_cnt_a, drop_cnt_a;

    logic        flush_b, in_valid_b, nn_done_b;
    logic [15:0] in_data1_b, in_data2_b;
    logic        in_ready_b, fifo_valid_b, fifo_clr_b, nn_start_b, window_busy_b, timeout_err_b;
    logic [15:0] fifo_data1_b, fifo_data2_b, infer_cnt_b, drop_cnt_b;

    int checks;
    int errors;

    feature_window_scheduler #(
        .NN_DATA_WIDTH (16),
        .NN_ARRAY_WIDTH(26),
        .HOP_PAIRS     (4),
        .SETTLE_CYC    (2),
        .NN_TIMEOUT    (16)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_a),
        .in_valid   (in_valid_a),
        .in_data1   (in_data1_a),
        .in_data2   (in_data2_a),
        .in_ready   (in_ready_a),
        .fifo_valid (fifo_valid_a),
        .fifo_data1 (fifo_data1_a),
        .fifo_data2 (fifo_data2_a),
        .fifo_clr   (fifo_clr_a),
        .nn_start   (nn_start_a),
        .nn_done    (nn_done_a),
        .window_busy(window_busy_a),
        .timeout_err(timeout_err_a),
        .infer_cnt  (infer_cnt_a),
        .drop_cnt   (drop_cnt_a)
    );

    feature_window_scheduler #(
        .NN_DATA_WIDTH (16),
        .NN_ARRAY_WIDTH(26),
        .HOP_PAIRS     (13),
        .SETTLE_CYC    (2),
        .NN_TIMEOUT    (100000)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush_b),
        .in_valid   (in_valid_b),
        .in_data1   (in_data1_b),
        .in_data2   (in_data2_b),
        .in_ready   (in_ready_b),
        .fifo_valid (fifo_valid_b),
        .fifo_data1 (fifo_data1_b),
        .fifo_data2 (fifo_data2_b),
        .fifo_clr   (fifo_clr_b),
        .nn_start   (nn_start_b),
        .nn_done    (nn_done_b),
        .window_busy(window_busy_b),
        .timeout_err(timeout_err_b),
        .infer_cnt  (infer_cnt_b),
        .drop_cnt   (drop_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; nn_done_a = 1'b0; in_data1_a = '0; in_data2_a = '0;
        flush_b = 1'b0; in_valid_b = 1'b0; nn_done_b = 1'b0; in_data1_b = '0; in_data2_b = '0;

        // Reset state
        step();
        chk1("rst_fifo_clr", fifo_clr_a, 1'b1);
        chk1("rst_in_ready", in_ready_a, 1'b0);
        chk1("rst_fifo_valid", fifo_valid_a, 1'b0);
        chk1("rst_nn_start", nn_start_a, 1'b0);
        chk1("rst_busy", window_busy_a, 1'b0);
        chk16("rst_infer", infer_cnt_a, 16'd0);
        chk16("rst_drop", drop_cnt_a, 16'd0);
        rst_n = 1'b1;
        step();
        chk1("post_rst_ready", in_ready_a, 1'b1);
        chk1("post_rst_clr", fifo_clr_a, 1'b0);

        // 1: fill with 13 pairs, data forwarded one cycle later
        for (int k = 0; k < 13; k++) begin
            in_valid_a = 1'b1;
            in_data1_a = 16'h1000 + 16'(k);
            in_data2_a = 16'h2000 + 16'(k);
            step();
            chk1("fill_fifo_valid", fifo_valid_a, 1'b1);
            chk16("fill_data1", fifo_data1_a, 16'h1000 + 16'(k));
            chk16("fill_data2", fifo_data2_a, 16'h2000 + 16'(k));
            chk1("fill_nn_start", nn_start_a, 1'b0);
            chk1("fill_busy", window_busy_a, (k == 12));
        end
        in_valid_a = 1'b0;
        chk1("settle_ready", in_ready_a, 1'b0);
        step();
        chk1("settle_fifo_valid", fifo_valid_a, 1'b0);
        chk1("settle_nn_start", nn_start_a, 1'b0);
        step();
        chk1("start1_pulse", nn_start_a, 1'b1);
        chk16("start1_infer", infer_cnt_a, 16'd1);
        step();
        chk1("start1_end", nn_start_a, 1'b0);
        chk1("busy1", window_busy_a, 1'b1);

        // 2: drops while busy, then nn_done slides
        for (int k = 0; k < 5; k++) begin
            in_valid_a = 1'b1;
            in_data1_a = 16'hDEAD;
            in_data2_a = 16'hBEEF;
            step();
            chk1("busy_ready", in_ready_a, 1'b0);
            chk1("busy_fifo_valid", fifo_valid_a, 1'b0);
        end
        in_valid_a = 1'b0;
        chk16("busy_drop5", drop_cnt_a, 16'd5);
        chk16("busy_data_hold", fifo_data1_a, 16'h100C);
        nn_done_a = 1'b1;
        step();
        nn_done_a = 1'b0;
        chk1("slide_ready", in_ready_a, 1'b1);
        chk1("slide_not_busy", window_busy_a, 1'b0);
        chk1("slide_no_timeout", timeout_err_a, 1'b0);

        // 3: hop of 4 pairs
        for (int k = 0; k < 4; k++) begin
            in_valid_a = 1'b1;
            in_data1_a = 16'h3000 + 16'(k);
            in_data2_a = 16'h4000 + 16'(k);
            step();
            chk1("hop_fifo_valid", fifo_valid_a, 1'b1);
            chk1("hop_busy", window_busy_a, (k == 3));
        end
        in_valid_a = 1'b0;
        chk16("hop_data2", fifo_data2_a, 16'h4003);
        step();
        chk1("hop_settle", nn_start_a, 1'b0);
        step();
        chk1("start2_pulse", nn_start_a, 1'b1);
        chk16("start2_infer", infer_cnt_a, 16'd2);
        step();
        chk1("start2_end", nn_start_a, 1'b0);

        // 4: no nn_done, timeout after 16 busy cycles
        for (int k = 1; k < 16; k++) begin
            step();
            chk1("wait_no_timeout", timeout_err_a, 1'b0);
            chk1("wait_busy", window_busy_a, 1'b1);
        end
        step();
        chk1("timeout_pulse", timeout_err_a, 1'b1);
        chk1("timeout_slide_ready", in_ready_a, 1'b1);
        chk1("timeout_not_busy", window_busy_a, 1'b0);
        step();
        chk1("timeout_end", timeout_err_a, 1'b0);

        // 5: flush into FILL, 7 pairs, flush with pair in flight, then 13 pairs
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk1("flush1_clr", fifo_clr_a, 1'b1);
        chk1("flush1_ready", in_ready_a, 1'b1);
        for (int k = 0; k < 7; k++) begin
            in_valid_a = 1'b1;
            in_data1_a = 16'h5000 + 16'(k);
            in_data2_a = 16'h6000 + 16'(k);
            step();
        end
        chk1("flush2_pre_clr", fifo_clr_a, 1'b0);
        in_data1_a = 16'h7777;
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        chk1("flush2_clr", fifo_clr_a, 1'b1);
        chk1("flush2_fifo_valid", fifo_valid_a, 1'b0);
        chk16("flush2_data_hold", fifo_data1_a, 16'h5006);
        chk16("flush2_drop_kept", drop_cnt_a, 16'd5);
        chk16("flush2_infer_kept", infer_cnt_a, 16'd2);
        for (int k = 0; k < 13; k++) begin
            in_data1_a = 16'h8000 + 16'(k);
            step();
            chk1("refill_busy", window_busy_a, (k == 12));
            chk1("refill_no_start", nn_start_a, 1'b0);
        end
        in_valid_a = 1'b0;
        step();
        step();
        chk1("start3_pulse", nn_start_a, 1'b1);
        chk16("start3_infer", infer_cnt_a, 16'd3);

        // 6: saturate drop_cnt on dut_b, then nn_done outside BUSY
        in_valid_b = 1'b1;
        for (int k = 0; k < 65600; k++) begin
            in_data1_b = 16'(k);
            step();
        end
        in_valid_b = 1'b0;
        chk16("sat_drop", drop_cnt_b, 16'hFFFF);
        chk1("sat_busy", window_busy_b, 1'b1);
        chk16("sat_infer", infer_cnt_b, 16'd1);
        nn_done_b = 1'b1;
        step();
        nn_done_b = 1'b0;
        chk1("sat_slide_ready", in_ready_b, 1'b1);
        flush_b = 1'b1;
        step();
        flush_b = 1'b0;
        chk1("sat_flush_clr", fifo_clr_b, 1'b1);
        chk16("sat_flush_drop", drop_cnt_b, 16'hFFFF);
        nn_done_b = 1'b1;
        step();
        nn_done_b = 1'b0;
        chk1("fill_done_ignored_ready", in_ready_b, 1'b1);
        chk1("fill_done_ignored_busy", window_busy_b, 1'b0);
        chk1("fill_done_no_start", nn_start_b, 1'b0);
        for (int k = 0; k < 13; k++) begin
            in_valid_b = 1'b1;
            step();
            chk1("b_refill_busy", window_busy_b, (k == 12));
        end
        in_valid_b = 1'b0;
        step();
        step();
        chk1("b_start_pulse", nn_start_b, 1'b1);
        chk16("b_infer", infer_cnt_b, 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
